sdram_arbiter: RTL

- Shares the single byte-wide SDRAM controller port between three requesters:
  - port 0: CPU.
  - port 1: ROM/cartridge loader.
  - port 2: disk/tape DMA.
- Issues at most one access per clkref slot, aligned to the controller's slot counter.
- Drives the controller's addr/din/oe/we, captures read data and returns a one-clock ack to the winning requester.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-port SDRAM slot arbiter.
package sdram_arb_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 23;

    typedef enum logic [1:0] {
        P_CPU  = 2'd0,
        P_LOAD = 2'd1,
        P_DMA  = 2'd2
    } port_id_t;

    typedef logic [0:0] state_t;
    localparam state_t S_IDLE   = 1'b0;
    localparam state_t S_ACCESS = 1'b1;

endpackage

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: one access per clkref slot; CPU has fixed priority, loader/DMA round-robin; completes RD_LAT+1 clk after slot-start.
// Requesters hold req until their one-clock ack; SDRAM_ARB_REFRESH_EN forces an idle slot after REFRESH_SLOTS consecutive grants.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int RD_LAT        = 8,
    parameter int INIT_SLOTS    = 32,
    parameter int REFRESH_SLOTS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clkref,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    output logic              mem_oe,
    output logic              mem_we,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [7:0]        p0_din,
    output logic [7:0]        p0_dout,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p1_din,
    output logic [7:0]        p1_dout,
    output logic              p1_ack,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [7:0]        p2_din,
    output logic [7:0]        p2_dout,
    output logic              p2_ack
);

    localparam int         INIT_W   = $clog2(INIT_SLOTS + 1);
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

    if (RD_LAT < 8 || RD_LAT > 14) begin : g_bad_rd_lat
        $error("RD_LAT must be in 8..14");
    end
    if (REFRESH_SLOTS < 1) begin : g_bad_refresh
        $error("REFRESH_SLOTS must be at least 1");
    end

    logic                           clkref_q;
    logic                           slot_start;
    logic [3:0]                     cnt_q, cnt_d;
    state_t                         state_q, state_d;
    port_id_t                       win_q, win_d;
    port_id_t                       rr_q, rr_d;
    logic [INIT_W-1:0]              init_q, init_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [7:0]                     din_q, din_d;
    logic                           oe_q, oe_d;
    logic                           we_q, we_d;
    logic [NUM_PORTS-1:0][7:0]      dout_q, dout_d;
    logic [NUM_PORTS-1:0]           ack_q, ack_d;

    logic [NUM_PORTS-1:0]           req;
    port_id_t                       pick;
    logic                           grant_ok;
    logic [ADDR_W-1:0]              sel_addr;
    logic [7:0]                     sel_din;
    logic                           sel_we;

    assign slot_start = clkref & ~clkref_q;
    assign req        = {p2_req, p1_req, p0_req};

`ifdef SDRAM_ARB_REFRESH_EN
    localparam int REF_W = $clog2(REFRESH_SLOTS + 1);
    logic [REF_W-1:0] ref_q, ref_d;

    // A full run of granted slots holds off the next grant so the controller can refresh.
    assign grant_ok = (|req) && (ref_q != REF_W'(REFRESH_SLOTS));

    always_comb begin
        ref_d = ref_q;
        if (state_q == S_IDLE && slot_start && init_q == '0) begin
            ref_d = grant_ok ? ref_q + REF_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_q <= '0;
        end else begin
            ref_q <= ref_d;
        end
    end
`else
    assign grant_ok = |req;
`endif

    always_comb begin
        pick = P_DMA;
        if (req[0]) begin
            pick = P_CPU;
        end else if (req[1] && req[2]) begin
            pick = rr_q;
        end else if (req[1]) begin
            pick = P_LOAD;
        end
    end

    always_comb begin
        sel_addr = p2_addr;
        sel_din  = p2_din;
        sel_we   = p2_we;
        case (pick)
            P_CPU: begin
                sel_addr = p0_addr;
                sel_din  = p0_din;
                sel_we   = p0_we;
            end
            P_LOAD: begin
                sel_addr = p1_addr;
                sel_din  = p1_din;
                sel_we   = p1_we;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d   = slot_start ? 4'd0 : ((cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1);
        state_d = state_q;
        win_d   = win_q;
        rr_d    = rr_q;
        init_d  = init_q;
        addr_d  = addr_q;
        din_d   = din_q;
        oe_d    = oe_q;
        we_d    = we_q;
        dout_d  = dout_q;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (slot_start) begin
                    if (init_q != '0) begin
                        init_d = init_q - INIT_W'(1);
                    end else if (grant_ok) begin
                        win_d   = pick;
                        addr_d  = sel_addr;
                        din_d   = sel_din;
                        oe_d    = ~sel_we;
                        we_d    = sel_we;
                        state_d = S_ACCESS;
                        if (pick != P_CPU) begin
                            rr_d = (pick == P_LOAD) ? P_DMA : P_LOAD;
                        end
                    end
                end
            end
            default: begin
                // Completion is driven by cnt alone; a slot-start here never grants.
                if (cnt_q == RD_LAT_C) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (win_q == 2'(i)) begin
                            ack_d[i] = 1'b1;
                            if (!we_q) begin
                                dout_d[i] = mem_dout;
                            end
                        end
                    end
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkref_q <= 1'b0;
            cnt_q    <= 4'd0;
            state_q  <= S_IDLE;
            win_q    <= P_CPU;
            rr_q     <= P_LOAD;
            init_q   <= INIT_W'(INIT_SLOTS);
            addr_q   <= '0;
            din_q    <= 8'h00;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            dout_q   <= {NUM_PORTS{8'hFF}};
            ack_q    <= '0;
        end else begin
            clkref_q <= clkref;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            win_q    <= win_d;
            rr_q     <= rr_d;
            init_q   <= init_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            dout_q   <= dout_d;
            ack_q    <= ack_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign mem_oe   = oe_q;
    assign mem_we   = we_q;
    assign p0_dout  = dout_q[0];
    assign p1_dout  = dout_q[1];
    assign p2_dout  = dout_q[2];
    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p2_ack   = ack_q[2];

endmodule
